// File: rtl/seq_alu.sv
// Sequential RV32I/M-style ALU: single-cycle base ops, DATA_WIDTH-cycle iterative multiply/divide.
// Strict valid/ready: a transfer happens only in a cycle where valid && ready at the rising edge.
module seq_alu #(
  parameter int DATA_WIDTH = 32,
  parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            func3,
  input  logic [6:0]            func7,
  input  logic [DATA_WIDTH-1:0] rs1_data,
  input  logic [DATA_WIDTH-1:0] rs2_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  illegal,
  output logic [1:0]            dbg_state
);
  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [W-1:0]       r_hi, r_lo, r_b, r_rs1, r_result;
  logic [2:0]         r_op;
  logic               r_neg, r_div0, r_illegal;

  logic               w_accept, w_is_m, w_last;
  logic [SHAMT_W-1:0] w_shamt;
  logic [W-1:0]       w_base;
  logic               w_base_ill;
  logic               w_sa_en, w_sb_en, w_sa, w_sb;
  logic [W-1:0]       w_amag, w_bmag;
  logic [W:0]         w_sum, w_shift;
  logic               w_ge;
  logic [W-1:0]       w_diff, w_hi_n, w_lo_n, w_final;
  logic [2*W-1:0]     w_prod, w_prod_s;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign rd_data   = out_valid ? r_result : '0;
  assign illegal   = out_valid & r_illegal;
  assign dbg_state = r_state;
  assign w_accept  = in_valid && in_ready;
  assign w_is_m    = (func7 == 7'b0000001);
  assign w_last    = (r_cnt == CNT_W'(DATA_WIDTH - 1));
  assign w_shamt   = rs2_data[SHAMT_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = w_is_m ? BUSY : DONE;
      BUSY:    if (w_last) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_base     = '0;
    w_base_ill = 1'b0;
    case ({func7, func3})
      {7'b0000000, 3'b000}: w_base = rs1_data + rs2_data;
      {7'b0100000, 3'b000}: w_base = rs1_data - rs2_data;
      {7'b0000000, 3'b001}: w_base = rs1_data << w_shamt;
      {7'b0000000, 3'b010}: w_base = {{(W-1){1'b0}}, ($signed(rs1_data) < $signed(rs2_data))};
      {7'b0000000, 3'b011}: w_base = {{(W-1){1'b0}}, (rs1_data < rs2_data)};
      {7'b0000000, 3'b100}: w_base = rs1_data ^ rs2_data;
      {7'b0000000, 3'b101}: w_base = rs1_data >> w_shamt;
      {7'b0100000, 3'b101}: w_base = $signed(rs1_data) >>> w_shamt;
      {7'b0000000, 3'b110}: w_base = rs1_data | rs2_data;
      {7'b0000000, 3'b111}: w_base = rs1_data & rs2_data;
      default:              w_base_ill = 1'b1;
    endcase
  end

  // Which operands are treated as signed for each M op (MUL low half is sign-agnostic).
  always_comb begin
    w_sa_en = 1'b0;
    w_sb_en = 1'b0;
    case (func3)
      3'b001, 3'b100, 3'b110: begin w_sa_en = 1'b1; w_sb_en = 1'b1; end
      3'b010:                 w_sa_en = 1'b1;
      default:                ;
    endcase
  end

  assign w_sa   = w_sa_en & rs1_data[W-1];
  assign w_sb   = w_sb_en & rs2_data[W-1];
  assign w_amag = w_sa ? -rs1_data : rs1_data;
  assign w_bmag = w_sb ? -rs2_data : rs2_data;

  // One multiply (shift-add) or restoring-divide step on {r_hi, r_lo}.
  assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_shift = {r_hi, r_lo[W-1]};
  assign w_ge    = (w_shift >= {1'b0, r_b});
  assign w_diff  = w_shift[W-1:0] - r_b;

  always_comb begin
    if (r_op[2]) begin
      w_hi_n = w_ge ? w_diff : w_shift[W-1:0];
      w_lo_n = {r_lo[W-2:0], w_ge};
    end else begin
      w_hi_n = w_sum[W:1];
      w_lo_n = {w_sum[0], r_lo[W-1:1]};
    end
  end

  assign w_prod   = {w_hi_n, w_lo_n};
  assign w_prod_s = r_neg ? -w_prod : w_prod;

  always_comb begin
    w_final = '0;
    if (!r_op[2])    w_final = (r_op == 3'b000) ? w_prod_s[W-1:0] : w_prod_s[2*W-1:W];
    else if (r_div0) w_final = r_op[1] ? r_rs1 : '1;
    else if (r_op[1]) w_final = r_neg ? -w_hi_n : w_hi_n;
    else             w_final = r_neg ? -w_lo_n : w_lo_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_b       <= '0;
      r_rs1     <= '0;
      r_op      <= '0;
      r_neg     <= 1'b0;
      r_div0    <= 1'b0;
      r_result  <= '0;
      r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= '0;
      if (w_is_m) begin
        r_hi      <= '0;
        r_lo      <= w_amag;
        r_b       <= w_bmag;
        r_rs1     <= rs1_data;
        r_op      <= func3;
        // Remainder follows the dividend's sign; everything else takes the XOR of signs.
        r_neg     <= (func3 == 3'b110) ? w_sa : (w_sa ^ w_sb);
        r_div0    <= func3[2] & (rs2_data == '0);
        r_illegal <= 1'b0;
      end else begin
        r_result  <= w_base;
        r_illegal <= w_base_ill;
      end
    end else if (r_state == BUSY) begin
      r_hi  <= w_hi_n;
      r_lo  <= w_lo_n;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) r_result <= w_final;
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu at DATA_WIDTH = 32: vector table, random ops, stall and reset-abort sequences.
module tb_seq_alu;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   func3 = '0;
  logic [6:0]   func7 = '0;
  logic [W-1:0] rs1_data = '0;
  logic [W-1:0] rs2_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] rd_data;
  logic         illegal;
  logic [1:0]   dbg_state;

  seq_alu #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .func3(func3), .func7(func7), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .rd_data(rd_data),
    .illegal(illegal), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]   f7;
    logic [2:0]   f3;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_d;
    logic         exp_ill;
  } vec_t;

  vec_t       vt[$];
  logic [W:0] exp_q[$];
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_op(input logic [6:0] f7, input logic [2:0] f3,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp_d, input logic exp_ill, input int stall);
    int         n;
    int         lat;
    logic [W:0] got;
    lat = (f7 == 7'b0000001) ? W + 1 : 1;
    @(negedge clk);
    out_ready = (stall == 0);
    func7 = f7; func3 = f3; rs1_data = a; rs2_data = b; in_valid = 1'b1;
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    @(posedge clk);
    exp_q.push_back({exp_ill, exp_d});
    @(negedge clk);
    in_valid = 1'b0;
    rs1_data = $urandom; rs2_data = $urandom;
    n = 1;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 64'(n), 64'(lat));
    for (int i = 0; i < stall; i++) begin
      chk("stall_rd_data", 64'(rd_data), 64'(exp_q[0][W-1:0]));
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_out_valid", 64'(out_valid), 64'd1);
      func7 = 7'b0000000; func3 = 3'b000; rs1_data = 1; rs2_data = 1; in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    got = exp_q.pop_front();
    chk("rd_data", 64'(rd_data), 64'(got[W-1:0]));
    chk("illegal", 64'(illegal), 64'(got[W]));
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_hs_out_valid", 64'(out_valid), 64'd0);
    chk("post_hs_rd_data", 64'(rd_data), 64'd0);
    chk("post_hs_in_ready", 64'(in_ready), 64'd1);
    if (stall > 0) begin
      @(negedge clk);
      chk("held_req_not_taken", 64'(out_valid), 64'd0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt.push_back('{7'h20, 3'd0, 32'd5,         32'd7,         32'hFFFFFFFE, 1'b0});
    vt.push_back('{7'h00, 3'd0, 32'hFFFFFFFF,  32'd2,         32'h00000001, 1'b0});
    vt.push_back('{7'h20, 3'd5, 32'h80000000,  32'h00000024,  32'hF8000000, 1'b0});
    vt.push_back('{7'h00, 3'd2, 32'hFFFFFFFF,  32'd1,         32'd1,        1'b0});
    vt.push_back('{7'h00, 3'd3, 32'hFFFFFFFF,  32'd1,         32'd0,        1'b0});
    vt.push_back('{7'h00, 3'd1, 32'd1,         32'h00000021,  32'd2,        1'b0});
    vt.push_back('{7'h00, 3'd5, 32'h80000000,  32'd4,         32'h08000000, 1'b0});
    vt.push_back('{7'h00, 3'd4, 32'hF0F0F0F0,  32'h0FF00FF0,  32'hFF00FF00, 1'b0});
    vt.push_back('{7'h00, 3'd6, 32'h00FF0000,  32'h0000FF00,  32'h00FFFF00, 1'b0});
    vt.push_back('{7'h00, 3'd7, 32'hF0F0F0F0,  32'h3C3C3C3C,  32'h30303030, 1'b0});
    vt.push_back('{7'h01, 3'd1, 32'h80000000,  32'h80000000,  32'h40000000, 1'b0});
    vt.push_back('{7'h01, 3'd3, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE, 1'b0});
    vt.push_back('{7'h01, 3'd0, 32'h00012345,  32'h00000010,  32'h00123450, 1'b0});
    vt.push_back('{7'h01, 3'd0, 32'hFFFFFFFF,  32'd3,         32'hFFFFFFFD, 1'b0});
    vt.push_back('{7'h01, 3'd2, 32'hFFFFFFFF,  32'd2,         32'hFFFFFFFF, 1'b0});
    vt.push_back('{7'h01, 3'd4, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD, 1'b0});
    vt.push_back('{7'h01, 3'd6, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF, 1'b0});
    vt.push_back('{7'h01, 3'd5, 32'd9,         32'd0,         32'hFFFFFFFF, 1'b0});
    vt.push_back('{7'h01, 3'd7, 32'd9,         32'd0,         32'd9,        1'b0});
    vt.push_back('{7'h01, 3'd4, 32'h80000000,  32'hFFFFFFFF,  32'h80000000, 1'b0});
    vt.push_back('{7'h01, 3'd6, 32'h80000000,  32'hFFFFFFFF,  32'd0,        1'b0});
    vt.push_back('{7'h01, 3'd4, 32'hFFFFFFF9,  32'd0,         32'hFFFFFFFF, 1'b0});
    vt.push_back('{7'h01, 3'd6, 32'hFFFFFFF9,  32'd0,         32'hFFFFFFF9, 1'b0});
    vt.push_back('{7'h01, 3'd5, 32'd100,       32'd7,         32'd14,       1'b0});
    vt.push_back('{7'h01, 3'd7, 32'd100,       32'd7,         32'd2,        1'b0});
    vt.push_back('{7'h01, 3'd4, 32'd20,        32'hFFFFFFFD,  32'hFFFFFFFA, 1'b0});
    vt.push_back('{7'h01, 3'd6, 32'd20,        32'hFFFFFFFD,  32'd2,        1'b0});
    vt.push_back('{7'h7F, 3'd0, 32'd5,         32'd6,         32'd0,        1'b1});
    vt.push_back('{7'h20, 3'd1, 32'd5,         32'd6,         32'd0,        1'b1});

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_rd_data", 64'(rd_data), 64'd0);
    chk("reset_illegal", 64'(illegal), 64'd0);
    chk("reset_state", 64'(dbg_state), 64'd0);

    foreach (vt[i]) run_op(vt[i].f7, vt[i].f3, vt[i].a, vt[i].b, vt[i].exp_d, vt[i].exp_ill, 0);

    for (int i = 0; i < 8; i++) begin
      logic [W-1:0] a, b, e;
      int           op;
      op = $urandom_range(0, 3);
      a  = $urandom;
      b  = (op == 3) ? W'($urandom_range(1, 1000)) : W'($urandom);
      case (op)
        0:       begin e = a + b; run_op(7'h00, 3'd0, a, b, e, 1'b0, 0); end
        1:       begin e = a - b; run_op(7'h20, 3'd0, a, b, e, 1'b0, 0); end
        2:       begin e = a ^ b; run_op(7'h00, 3'd4, a, b, e, 1'b0, 0); end
        default: begin e = a / b; run_op(7'h01, 3'd5, a, b, e, 1'b0, 0); end
      endcase
    end

    // Result held under back-pressure while another request waits.
    run_op(7'h01, 3'd5, 32'd100, 32'd7, 32'd14, 1'b0, 5);

    // Reset during a divide: the aborted result must never surface.
    @(negedge clk);
    func7 = 7'h01; func3 = 3'd4; rs1_data = 32'd100; rs2_data = 32'd7; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("abort_busy_state", 64'(dbg_state), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_rd_data", 64'(rd_data), 64'd0);
    begin
      int seen = 0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      chk("abort_no_result", 64'(seen), 64'd0);
    end

    // A request coinciding with reset is ignored.
    func7 = 7'h00; func3 = 3'd0; rs1_data = 32'd1; rs2_data = 32'd2;
    rst = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    chk("rst_req_ignored", 64'(out_valid), 64'd0);
    chk("rst_req_in_ready", 64'(in_ready), 64'd1);

    run_op(7'h00, 3'd0, 32'd1, 32'd2, 32'd3, 1'b0, 0);
    run_op(7'h7F, 3'd0, 32'd1, 32'd2, 32'd0, 1'b1, 0);

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
